// File: rtl/barrier_multi.sv
// barrier_multi: holds requests that target a barrier address until every
// participant of that barrier has arrived, then releases all of them together
// and forwards their original requests. Several independent barriers are
// supported, each with a runtime participant mask, a release pulse and a
// wrapping generation counter.
//
// Each port runs a small Idle/Wait/Take FSM. Idle traps a barrier hit, Wait
// blocks the port until its barrier fires, and Take passes the held request
// downstream once. Take never re-traps, so the released access itself goes out.

module barrier_multi #(
    parameter int unsigned           NrPorts     = 4,
    parameter int unsigned           NrBarriers  = 2,
    parameter int unsigned           AddrWidth   = 32,
    parameter logic [AddrWidth-1:0]  BarrierBase = 32'h1234_bee0,
    parameter int unsigned           CntWidth    = 8
) (
    input  logic                           clk_i,
    input  logic                           rst_i,
    input  logic [NrPorts*AddrWidth-1:0]   in_addr_i,
    input  logic [NrPorts-1:0]             in_valid_i,
    output logic [NrPorts-1:0]             in_ready_o,
    output logic [NrPorts-1:0]             out_valid_o,
    input  logic [NrPorts-1:0]             out_ready_i,
    input  logic [NrBarriers*NrPorts-1:0]  part_mask_i,
    output logic [NrBarriers-1:0]          release_o,
    output logic [NrBarriers*CntWidth-1:0] gen_cnt_o
);

    localparam int unsigned IdWidth = (NrBarriers > 1) ? $clog2(NrBarriers) : 1;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_WAIT = 2'd1,
        ST_TAKE = 2'd2
    } state_e;

    // Address of barrier b.
    function automatic logic [AddrWidth-1:0] barrier_addr(input int b);
        return BarrierBase + (AddrWidth'(b) << 32'd2);
    endfunction

    // Index of the lowest set bit; the lowest barrier wins on multiple hits.
    function automatic logic [IdWidth-1:0] lowest_id(input logic [NrBarriers-1:0] vec);
        logic [IdWidth-1:0] id;
        id = '0;
        for (int b = int'(NrBarriers) - 1; b >= 0; b--) begin
            if (vec[b]) begin
                id = IdWidth'(b);
            end else begin
                id = id;
            end
        end
        return id;
    endfunction

    state_e                state_r      [NrPorts];
    state_e                state_next_s [NrPorts];
    logic [IdWidth-1:0]    id_r         [NrPorts];
    logic [IdWidth-1:0]    id_next_s    [NrPorts];
    logic [NrBarriers-1:0] hit_s        [NrPorts];
    logic [NrPorts-1:0]    waiting_s    [NrBarriers];
    logic [NrBarriers-1:0] fire_s;
    logic [CntWidth-1:0]   gen_cnt_r    [NrBarriers];

    // Barrier hit matrix: valid request on a barrier address with the port's mask bit set.
    always_comb begin
        for (int p = 0; p < int'(NrPorts); p++) begin
            for (int b = 0; b < int'(NrBarriers); b++) begin
                hit_s[p][b] = in_valid_i[p]
                           && (in_addr_i[p*AddrWidth +: AddrWidth] == barrier_addr(b))
                           && part_mask_i[b*NrPorts + p];
            end
        end
    end

    // Which ports are currently parked on each barrier.
    always_comb begin
        for (int b = 0; b < int'(NrBarriers); b++) begin
            for (int p = 0; p < int'(NrPorts); p++) begin
                waiting_s[b][p] = (state_r[p] == ST_WAIT) && (id_r[p] == IdWidth'(b));
            end
        end
    end

    // A barrier fires once every current participant is waiting on it.
    always_comb begin
        for (int b = 0; b < int'(NrBarriers); b++) begin
            fire_s[b] = (|waiting_s[b])
                     && ((waiting_s[b] & part_mask_i[b*NrPorts +: NrPorts])
                         == part_mask_i[b*NrPorts +: NrPorts]);
        end
    end

    // Per-port next state, captured barrier ID and handshake gating.
    always_comb begin
        for (int p = 0; p < int'(NrPorts); p++) begin
            state_next_s[p] = state_r[p];
            id_next_s[p]    = id_r[p];
            out_valid_o[p]  = in_valid_i[p];
            in_ready_o[p]   = out_ready_i[p];
            case (state_r[p])
                ST_IDLE: begin
                    if (|hit_s[p]) begin
                        state_next_s[p] = ST_WAIT;
                        id_next_s[p]    = lowest_id(hit_s[p]);
                        out_valid_o[p]  = 1'b0;
                        in_ready_o[p]   = 1'b0;
                    end else begin
                        state_next_s[p] = ST_IDLE;
                    end
                end
                ST_WAIT: begin
                    out_valid_o[p] = 1'b0;
                    in_ready_o[p]  = 1'b0;
                    if ((int'(id_r[p]) < int'(NrBarriers)) && fire_s[id_r[p]]) begin
                        state_next_s[p] = ST_TAKE;
                    end else begin
                        state_next_s[p] = ST_WAIT;
                    end
                end
                ST_TAKE: begin
                    if (in_valid_i[p] && out_ready_i[p]) begin
                        state_next_s[p] = ST_IDLE;
                    end else begin
                        state_next_s[p] = ST_TAKE;
                    end
                end
                default: begin
                    state_next_s[p] = ST_IDLE;
                    id_next_s[p]    = '0;
                    out_valid_o[p]  = 1'b0;
                    in_ready_o[p]   = 1'b0;
                end
            endcase
        end
    end

    // Port state and barrier ID registers; reset drops any wait without releasing.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            for (int p = 0; p < int'(NrPorts); p++) begin
                state_r[p] <= ST_IDLE;
                id_r[p]    <= '0;
            end
        end else begin
            for (int p = 0; p < int'(NrPorts); p++) begin
                state_r[p] <= state_next_s[p];
                id_r[p]    <= id_next_s[p];
            end
        end
    end

    // Generation counters advance the cycle after each release and wrap naturally.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            for (int b = 0; b < int'(NrBarriers); b++) begin
                gen_cnt_r[b] <= '0;
            end
        end else begin
            for (int b = 0; b < int'(NrBarriers); b++) begin
                gen_cnt_r[b] <= gen_cnt_r[b] + CntWidth'(fire_s[b]);
            end
        end
    end

    // Flatten counters onto the output bus.
    always_comb begin
        for (int b = 0; b < int'(NrBarriers); b++) begin
            gen_cnt_o[b*CntWidth +: CntWidth] = gen_cnt_r[b];
        end
    end

    assign release_o = fire_s;

    barrier_multi_checker #(
        .NrPorts (NrPorts)
    ) i_checker (
        .clk_i       (clk_i),
        .rst_i       (rst_i),
        .in_valid_i  (in_valid_i),
        .in_ready_o  (in_ready_o),
        .out_valid_o (out_valid_o),
        .out_ready_i (out_ready_i)
    );

endmodule

// Interface properties: the block may only gate handshakes, never create them.
module barrier_multi_checker #(
    parameter int unsigned NrPorts = 4
) (
    input logic               clk_i,
    input logic               rst_i,
    input logic [NrPorts-1:0] in_valid_i,
    input logic [NrPorts-1:0] in_ready_o,
    input logic [NrPorts-1:0] out_valid_o,
    input logic [NrPorts-1:0] out_ready_i
);

    valid_only_from_request: assert property (
        @(posedge clk_i) disable iff (rst_i) ((out_valid_o & ~in_valid_i) == '0));

    ready_only_from_downstream: assert property (
        @(posedge clk_i) disable iff (rst_i) ((in_ready_o & ~out_ready_i) == '0));

endmodule

// File: tb/tb_barrier_multi.sv
// Self-checking bench for barrier_multi: directed scenarios plus randomized
// traffic, all compared against a set-based reference model of the barriers.

module tb_barrier_multi;

    localparam int NP = 4;
    localparam int NB = 2;
    localparam int AW = 32;
    localparam int CW = 8;
    localparam logic [31:0] BASE = 32'h1234_bee0;

    logic              clk;
    logic              rst_i;
    logic [NP*AW-1:0]  in_addr_i;
    logic [NP-1:0]     in_valid_i;
    logic [NP-1:0]     in_ready_o;
    logic [NP-1:0]     out_valid_o;
    logic [NP-1:0]     out_ready_i;
    logic [NB*NP-1:0]  part_mask_i;
    logic [NB-1:0]     release_o;
    logic [NB*CW-1:0]  gen_cnt_o;

    int n_vec = 0;
    int n_err = 0;

    // Reference model: set of ports held at each barrier, set of released
    // ports still owing their forwarded access, and a release count per barrier.
    logic [NP-1:0] m_held [NB];
    logic [NP-1:0] m_freed;
    int            m_cnt  [NB];
    logic [NP-1:0] exp_valid;
    logic [NP-1:0] exp_ready;
    logic [NB-1:0] exp_rel;
    int            trap_b [NP];

    logic [NP-1:0] req_v;
    logic [AW-1:0] req_a [NP];

    barrier_multi dut (
        .clk_i       (clk),
        .rst_i       (rst_i),
        .in_addr_i   (in_addr_i),
        .in_valid_i  (in_valid_i),
        .in_ready_o  (in_ready_o),
        .out_valid_o (out_valid_o),
        .out_ready_i (out_ready_i),
        .part_mask_i (part_mask_i),
        .release_o   (release_o),
        .gen_cnt_o   (gen_cnt_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    function automatic logic [31:0] baddr(input int b);
        return BASE + 32'(4 * b);
    endfunction

    function automatic logic [NP-1:0] mask_of(input int b);
        return part_mask_i[b*NP +: NP];
    endfunction

    task automatic set_mask(input int b, input logic [NP-1:0] m);
        part_mask_i[b*NP +: NP] = m;
    endtask

    task automatic set_port(input int p, input logic v, input logic [31:0] a);
        in_valid_i[p]          = v;
        in_addr_i[p*AW +: AW]  = a;
    endtask

    task automatic model_reset();
        for (int b = 0; b < NB; b++) begin
            m_held[b] = '0;
            m_cnt[b]  = 0;
        end
        m_freed = '0;
    endtask

    // Predict this cycle's outputs from the model and compare.
    task automatic eval_cycle();
        logic held_any;
        #1;
        for (int b = 0; b < NB; b++) begin
            exp_rel[b] = (m_held[b] != '0) && ((m_held[b] & mask_of(b)) == mask_of(b));
        end
        for (int p = 0; p < NP; p++) begin
            held_any = 1'b0;
            for (int b = 0; b < NB; b++) held_any = held_any | m_held[b][p];
            trap_b[p] = -1;
            if (!held_any && !m_freed[p]) begin
                for (int b = NB - 1; b >= 0; b--) begin
                    if (in_valid_i[p] && in_addr_i[p*AW +: AW] == baddr(b) && mask_of(b)[p])
                        trap_b[p] = b;
                end
            end
            if (held_any || trap_b[p] >= 0) begin
                exp_valid[p] = 1'b0;
                exp_ready[p] = 1'b0;
            end else begin
                exp_valid[p] = in_valid_i[p];
                exp_ready[p] = out_ready_i[p];
            end
        end
        check_eq("out_valid", 32'(out_valid_o), 32'(exp_valid));
        check_eq("in_ready", 32'(in_ready_o), 32'(exp_ready));
        check_eq("release", 32'(release_o), 32'(exp_rel));
        for (int b = 0; b < NB; b++) begin
            check_eq($sformatf("gen_cnt%0d", b), 32'(gen_cnt_o[b*CW +: CW]), 32'(m_cnt[b] % 256));
        end
    endtask

    // Advance one clock and update the model with the same inputs.
    task automatic tick();
        @(posedge clk);
        if (rst_i) begin
            model_reset();
        end else begin
            for (int p = 0; p < NP; p++) begin
                if (m_freed[p] && in_valid_i[p] && out_ready_i[p]) m_freed[p] = 1'b0;
            end
            for (int b = 0; b < NB; b++) begin
                if (exp_rel[b]) begin
                    m_freed   = m_freed | m_held[b];
                    m_held[b] = '0;
                    m_cnt[b]  = (m_cnt[b] + 1) % 256;
                end
            end
            for (int p = 0; p < NP; p++) begin
                if (trap_b[p] >= 0) m_held[trap_b[p]][p] = 1'b1;
            end
        end
        @(negedge clk);
    endtask

    task automatic do_reset();
        rst_i       = 1'b1;
        in_valid_i  = '0;
        out_ready_i = '1;
        tick();
        rst_i = 1'b0;
    endtask

    initial begin
        int fires;
        rst_i       = 1'b1;
        in_addr_i   = '0;
        in_valid_i  = '0;
        out_ready_i = '1;
        part_mask_i = '0;
        req_v       = '0;
        model_reset();
        for (int p = 0; p < NP; p++) trap_b[p] = -1;
        exp_rel = '0;
        @(negedge clk);
        do_reset();

        // Reset state
        eval_cycle();
        check_eq("rst_gen", 32'(gen_cnt_o), 32'd0);
        tick();

        // Staggered arrivals at barrier 0 with full mask
        set_mask(0, 4'b1111);
        set_mask(1, 4'b0000);
        for (int c = 0; c < 9; c++) begin
            if (c == 0) set_port(0, 1'b1, baddr(0));
            if (c == 2) set_port(1, 1'b1, baddr(0));
            if (c == 3) set_port(2, 1'b1, baddr(0));
            if (c == 5) set_port(3, 1'b1, baddr(0));
            if (c == 8) in_valid_i = '0;
            eval_cycle();
            if (c == 5) check_eq("s1_last_trap", 32'(out_valid_o), 32'd0);
            if (c == 5) check_eq("s1_no_early_rel", 32'(release_o), 32'd0);
            if (c == 6) check_eq("s1_release", 32'(release_o), 32'b01);
            if (c == 7) check_eq("s1_take", 32'(out_valid_o), 32'hF);
            if (c == 7) check_eq("s1_gen", 32'(gen_cnt_o[CW-1:0]), 32'd1);
            tick();
        end

        // Two barriers firing together
        do_reset();
        set_mask(0, 4'b0011);
        set_mask(1, 4'b1100);
        for (int c = 0; c < 4; c++) begin
            if (c == 0) begin
                set_port(0, 1'b1, baddr(0));
                set_port(1, 1'b1, baddr(0));
                set_port(2, 1'b1, baddr(1));
                set_port(3, 1'b1, baddr(1));
            end
            if (c == 3) in_valid_i = '0;
            eval_cycle();
            if (c == 1) check_eq("s2_release", 32'(release_o), 32'b11);
            if (c == 2) check_eq("s2_gen", 32'(gen_cnt_o), 32'h0101);
            tick();
        end

        // Barrier address without mask bit passes through
        do_reset();
        set_mask(0, 4'b0011);
        set_mask(1, 4'b0000);
        out_ready_i = 4'b0100;
        set_port(2, 1'b1, baddr(0));
        eval_cycle();
        check_eq("s3_pass_valid", 32'(out_valid_o[2]), 32'd1);
        check_eq("s3_pass_ready", 32'(in_ready_o[2]), 32'd1);
        tick();
        in_valid_i  = '0;
        out_ready_i = '1;

        // Clearing the late participant's bit fires the barrier
        do_reset();
        set_mask(0, 4'b0111);
        for (int c = 0; c < 13; c++) begin
            if (c == 0) begin
                set_port(0, 1'b1, baddr(0));
                set_port(1, 1'b1, baddr(0));
            end
            if (c == 10) set_mask(0, 4'b0011);
            if (c == 12) in_valid_i = '0;
            eval_cycle();
            if (c == 9)  check_eq("s4_hold", 32'(release_o), 32'd0);
            if (c == 10) check_eq("s4_release", 32'(release_o), 32'b01);
            if (c == 11) check_eq("s4_take", 32'(out_valid_o[1:0]), 32'b11);
            tick();
        end

        // Reset while ports wait
        do_reset();
        set_mask(0, 4'b1111);
        for (int c = 0; c < 6; c++) begin
            if (c == 0) for (int p = 0; p < 3; p++) set_port(p, 1'b1, baddr(0));
            rst_i = (c == 3);
            if (c == 4) set_mask(0, 4'b0000);
            if (c == 5) in_valid_i = '0;
            eval_cycle();
            if (c == 4) check_eq("s5_no_rel", 32'(release_o), 32'd0);
            if (c == 4) check_eq("s5_idle", 32'(out_valid_o[2:0]), 32'b111);
            if (c == 4) check_eq("s5_gen", 32'(gen_cnt_o), 32'd0);
            tick();
        end

        // Randomized traffic
        do_reset();
        set_mask(0, 4'b1111);
        set_mask(1, 4'b0011);
        req_v = '0;
        for (int c = 0; c < 3000; c++) begin
            if ($urandom_range(0, 29) == 0) set_mask(int'($urandom_range(0, 1)), 4'($urandom));
            rst_i = ($urandom_range(0, 299) == 0);
            for (int p = 0; p < NP; p++) begin
                if (!req_v[p] && $urandom_range(0, 3) == 0) begin
                    req_v[p] = 1'b1;
                    case ($urandom_range(0, 4))
                        0, 1:    req_a[p] = baddr(0);
                        2:       req_a[p] = baddr(1);
                        3:       req_a[p] = BASE + 32'd8;
                        default: req_a[p] = $urandom;
                    endcase
                end
                set_port(p, req_v[p] && ($urandom_range(0, 49) != 0), req_a[p]);
            end
            out_ready_i = 4'($urandom) | 4'($urandom);
            eval_cycle();
            for (int p = 0; p < NP; p++) begin
                if (in_valid_i[p] && exp_ready[p]) req_v[p] = 1'b0;
            end
            tick();
        end
        rst_i = 1'b0;

        // Generation counter wrap after 256 releases
        do_reset();
        set_mask(0, 4'b0001);
        set_mask(1, 4'b0000);
        out_ready_i = '1;
        fires = 0;
        for (int c = 0; c < 2000 && fires < 256; c++) begin
            set_port(0, 1'b1, baddr(0));
            eval_cycle();
            if (exp_rel[0]) fires++;
            tick();
        end
        check_eq("wrap_fires", 32'(fires), 32'd256);
        in_valid_i = '0;
        eval_cycle();
        check_eq("wrap_gen", 32'(gen_cnt_o[CW-1:0]), 32'd0);
        tick();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/barrier_multi.md
Name: barrier_multi

Overview:
- Generalised multi-barrier synchroniser between NrPorts request masters and the downstream interconnect.
- A port whose valid request targets one of NrBarriers barrier addresses is held until every port in that barrier's runtime participant mask has arrived.
- All held ports are then released together and their original request is forwarded.
- Adds multiple barrier IDs, runtime participant masks, release pulses and per-barrier generation counters.

Parameters:
- NrPorts, 4, number of request ports.
- NrBarriers, 2, number of independent barriers.
- AddrWidth, 32, request address width.
- BarrierBase, 32'h1234_bee0, address of barrier 0; barrier b is at BarrierBase + 4*b.
- CntWidth, 8, generation counter width.

Ports:
- clk_i  in  1  clock.
- rst_i  in  1  synchronous active-high reset.
- in_addr_i  in  NrPorts x AddrWidth  per-port request address.
- in_valid_i  in  NrPorts  per-port request valid.
- in_ready_o  out  NrPorts  per-port request ready.
- out_valid_o  out  NrPorts  per-port forwarded valid.
- out_ready_i  in  NrPorts  per-port downstream ready.
- part_mask_i  in  NrBarriers x NrPorts  participant mask per barrier; bit p set means port p takes part.
- release_o  out  NrBarriers  one-cycle pulse when barrier b fires.
- gen_cnt_o  out  NrBarriers x CntWidth  number of releases per barrier; wraps modulo 2^CntWidth.

Behaviour:
- One clock, synchronous active-high reset. On reset:
  - every port FSM goes to Idle, with stored barrier ID 0;
  - gen_cnt_o = 0 and release_o = 0;
  - combinational outputs follow the Idle rules below.
- Reset asserted mid-wait drops every waiting port to Idle with no release. The held request is then re-evaluated from Idle.
- hit[p][b] = in_valid_i[p] && in_addr_i[p] == BarrierBase + 4*b && part_mask_i[b][p].
  - A barrier address hit without the mask bit passes straight through, untrapped.
- Per-port FSM, states Idle/Wait/Take, with a registered barrier ID id_q[p]:
  - Idle, no hit: out_valid_o[p] = in_valid_i[p], in_ready_o[p] = out_ready_i[p].
  - Idle, hit on b: out_valid_o[p] = 0, in_ready_o[p] = 0; next state Wait, id_q[p] = b.
  - Wait: out_valid_o[p] = 0, in_ready_o[p] = 0. Go to Take the cycle after fire[id_q[p]].
  - Take: pass-through as Idle. Go to Idle on in_valid_i[p] && out_ready_i[p]; the same-cycle handshake is the forwarded barrier access. Take never re-traps.
- Fire condition, computed from registered state and current masks:
  - waiting[b][p] = (state[p] == Wait) && id_q[p] == b.
  - fire[b] = |waiting[b] && ((waiting[b] & part_mask_i[b]) == part_mask_i[b]).
  - Latency: the last arrival is registered in Wait at cycle t, fire is evaluated at t, and ports are in Take at t+1.
  - Minimum trap-to-forward delay is 2 cycles.
- On fire[b]:
  - release_o[b] = 1 for exactly that cycle;
  - gen_cnt_o[b] increments the following cycle;
  - every port with waiting[b] moves to Take, including ports whose mask bit has since been cleared.
- If a mask changes while ports wait, the condition is re-evaluated each cycle with the new mask. Clearing a late port's bit can therefore fire the barrier.
- If the mask is all-zero, nothing traps and the barrier never fires.
- A port arriving in the fire cycle is not included; it waits for the next generation.
- Several barriers may fire in the same cycle, independently.
- If in_valid_i drops while a port is in Wait, the port still stays in Wait; the protocol forbids dropping valid.
- If the address matches several barriers, the lowest index wins; this cannot happen with distinct addresses.

Test Plan:
- Mask b0 = 4'b1111; ports 0..3 hit BarrierBase at cycles 0, 2, 3, 5.
  - Required: out_valid_o = 0 for each port from its arrival cycle.
  - Required: release_o[0] pulses at cycle 6; all four ports show out_valid_o at cycle 7; gen_cnt_o[0] = 1 at cycle 7.
- Mask b0 = 4'b0011, b1 = 4'b1100; ports 0,1 hit b0 and ports 2,3 hit BarrierBase+4 in the same cycle.
  - Required: release_o = 2'b11 in the same cycle; both counters become 1.
- Port 2 hits barrier 0 with mask b0 = 4'b0011.
  - Required: no trap; out_valid_o[2] = in_valid_i[2] in the same cycle.
- Mask b0 = 4'b0111; ports 0,1 waiting; clear bit 2 at cycle 10.
  - Required: release_o[0] at cycle 10; ports 0,1 in Take at cycle 11.
- Ports 0..2 waiting on b0 (mask 4'b1111); assert rst_i for one cycle.
  - Required: all ports Idle next cycle, no release_o, gen_cnt_o = 0.
- Fire barrier 0 256 times with CntWidth = 8.
  - Required: gen_cnt_o[0] wraps to 0.
